if_id_hazard: RTL
=================

Name: if_id_hazard

Overview:
- IF/ID pipeline register merged with load-use hazard detection and branch flush control.
- Sits between instruction fetch and decode. Its outputs feed the decode stage, which feeds the ID/EX register.
- Drives the PC write enable and the ID/EX control bubble.
- Replaces a bare IF/ID latch so that stall, flush and global freeze are resolved in one place with a fixed priority.

Parameters:
- PC_W, 32, width of PC+4 value carried through the stage.
- INSTR_W, 32, instruction width; rs = [25:21], rt = [20:16].
- NOP_INSTR, 32'h0000_0000, instruction value loaded on reset and flush.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- pc_i  in  PC_W  PC+4 from fetch.
- instr_i  in  INSTR_W  instruction from instruction memory.
- idex_memread_i  in  1  MemRead of the instruction currently in ID/EX.
- idex_rt_i  in  5  destination rt of the instruction currently in ID/EX.
- branch_taken_i  in  1  taken branch/jump resolved in ID this cycle.
- mem_stall_i  in  1  global pipeline freeze (data memory busy).
- pc_o  out  PC_W  registered PC+4 to decode.
- instr_o  out  INSTR_W  registered instruction to decode.
- valid_o  out  1  instr_o holds a real instruction.
- pc_write_o  out  1  PC register update enable.
- bubble_o  out  1  forces ID/EX control inputs to zero this cycle.
- hazard_o  out  1  load-use hazard detected (debug/observe).

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - pc_r = 0, instr_r = NOP_INSTR, valid_r = 0.
  - Counters (if present) are cleared.
  - Reset overrides everything, including mid-stall.
- Hazard detection (combinational, from registered state):
  - hazard = valid_r & idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == instr_r[25:21] | idex_rt_i == instr_r[20:16]).
- Combinational outputs:
  - hazard_o = hazard.
  - pc_write_o = ~(hazard | mem_stall_i).
  - bubble_o = hazard & ~mem_stall_i.
  - pc_write_o is 1 and bubble_o is 0 while reset is held.
- Register update at the clock edge, in priority order:
  1. mem_stall_i = 1: hold pc_r, instr_r, valid_r.
  2. hazard = 1: hold. branch_taken_i is ignored, because a branch in a stalled ID is not yet valid.
  3. branch_taken_i = 1: pc_r = pc_i, instr_r = NOP_INSTR, valid_r = 0 (flush).
  4. Otherwise: pc_r = pc_i, instr_r = instr_i, valid_r = 1.
- Latency: one cycle from fetch to decode.
- Load-use stall length:
  - Exactly one cycle, because the bubble clears idex_memread_i on the next edge.
  - Under mem_stall_i the hazard persists and is re-evaluated after the freeze ends.
- Outputs come directly from registers; there is no combinational path from instr_i or pc_i to any output.
- An invalid (flushed) slot never raises a hazard.
- The first cycle after reset release loads normally.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (32) and output flush_cnt_o (32).
  - stall_cnt_o increments on each edge where hazard = 1 and mem_stall_i = 0.
  - flush_cnt_o increments on each edge where step 3 is taken.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then stream: rst_n_i low 2 cycles, then pc_i = 4, 8, 12 with instr_i = A, B, C.
  - instr_o = A, B, C one cycle later; valid_o rises with A; pc_write_o = 1 throughout.
- Load-use on rs: instr_r = 0x012A4020 (rs = 9), idex_memread_i = 1, idex_rt_i = 9.
  - hazard_o = 1, pc_write_o = 0, bubble_o = 1 for one cycle; instr_o held.
  - Next cycle idex_memread_i = 0 → new instr loads.
- rt = 0 exclusion: idex_memread_i = 1, idex_rt_i = 0, instr_r rs = 0.
  - hazard_o = 0, pc_write_o = 1.
- Branch flush: branch_taken_i = 1 with instr_i = 0xDEADBEEF.
  - Next cycle instr_o = 0, valid_o = 0, pc_o = pc_i.
  - Same stimulus with a simultaneous hazard: state held, no flush.
- Freeze: mem_stall_i = 1 for 3 cycles with a hazard present.
  - Outputs held, bubble_o = 0, pc_write_o = 0.
  - After release: bubble_o = 1 for one cycle.
- Async reset mid-stall: assert rst_n_i low between edges during a hazard.
  - valid_o = 0 and instr_o = 0 immediately.
  - With IF_ID_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and global freeze.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_hazard #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               idex_memread_i,
  input  logic [4:0]         idex_rt_i,
  input  logic               branch_taken_i,
  input  logic               mem_stall_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o,
  output logic               pc_write_o,
  output logic               bubble_o,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o,
`endif
  output logic               hazard_o
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  logic [PC_W-1:0]    pc_q,    pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [REG_W-1:0]   rs_c, rt_c;
  logic               hazard_c;
  logic               flush_c;

  // Hazard only depends on registered state and ID/EX sideband, never on fetch inputs.
  always_comb begin
    rs_c     = instr_q[25:21];
    rt_c     = instr_q[20:16];
    hazard_c = valid_q && idex_memread_i && (idex_rt_i != REG_W'(0)) &&
               ((idex_rt_i == rs_c) || (idex_rt_i == rt_c));
  end

  // Update priority: freeze, then load-use hold, then flush, then normal load.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    flush_c = 1'b0;
    if (mem_stall_i || hazard_c) begin
      pc_d    = pc_q;
    end else if (branch_taken_i) begin
      pc_d    = pc_i;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      flush_c = 1'b1;
    end else begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o     = pc_q;
  assign instr_o  = instr_q;
  assign valid_o  = valid_q;
  assign hazard_o = hazard_c;
  // Reset forces the PC enable on and the bubble off regardless of the freeze input.
  assign pc_write_o = !rst_n_i || !(hazard_c || mem_stall_i);
  assign bubble_o   = rst_n_i && hazard_c && !mem_stall_i;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard_c && !mem_stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_flush;
  assign unused_flush = flush_c;
`endif

endmodule
